clock_div_bank: RTL and testbench

Parametrised multi-channel clock-enable generator for the microwave controller. It replaces the fixed power-of-two tap selector with per-channel programmable integer dividers. Each channel produces either a one-cycle tick or a 50 % square wave derived from `sys_clk`. Divide and mode updates are shadowed and take effect only at a channel's terminal count, so downstream timers, display scan and buzzer logic never see a runt period.

---
 rtl/clock_div_pkg.sv | 14 +
 rtl/clock_div_channel.sv | 81 ++++++++
 rtl/clock_div_bank.sv | 60 ++++++
 tb/tb_clock_div_bank.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/clock_div_pkg.sv
// clock_div_pkg: shared constants for the clock-enable divider bank.
//   CLK_DIV_W       - default width of a divide value
//   CLK_DEFAULT_DIV - default divide value loaded at reset
//   MODE_TICK       - one-cycle pulse every N enabled cycles
//   MODE_SQUARE     - 50 % square wave of period 2N
package clock_div_pkg;

  localparam int unsigned CLK_DIV_W       = 16;
  localparam int unsigned CLK_DEFAULT_DIV = 1000;

  localparam logic MODE_TICK   = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

endpackage

// File: rtl/clock_div_channel.sv
// clock_div_channel: one programmable divider channel with shadowed config.
//   sys_clk  - system clock
//   rst      - synchronous active-low reset
//   en       - count enable; the channel freezes while low
//   wr       - write strobe already decoded for this channel
//   cfg_div  - new divide value (already clamped to >= 1)
//   cfg_mode - new output mode (MODE_TICK / MODE_SQUARE)
//   out_clk  - registered tick or square output
//   pending  - shadow config waiting for the next wrap
module clock_div_channel
  import clock_div_pkg::*;
#(
  parameter int unsigned DIV_W       = CLK_DIV_W,
  parameter int unsigned DEFAULT_DIV = CLK_DEFAULT_DIV
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic             out_clk,
  output logic             pending
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_a;
  logic [DIV_W-1:0] div_s;
  logic             mode_a;
  logic             mode_s;
  logic [DIV_W-1:0] last;
  logic             wrap;

  assign last = div_a - DIV_W'(1);
  assign wrap = en && (cnt == last);

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      cnt     <= '0;
      div_a   <= DIV_W'(DEFAULT_DIV);
      div_s   <= DIV_W'(DEFAULT_DIV);
      mode_a  <= MODE_TICK;
      mode_s  <= MODE_TICK;
      out_clk <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (wrap) begin
        cnt <= '0;
        // A mode switch parks the output low; otherwise the old mode acts.
        if (pending && (mode_s != mode_a)) begin
          out_clk <= 1'b0;
        end else if (mode_a == MODE_TICK) begin
          out_clk <= 1'b1;
        end else begin
          out_clk <= ~out_clk;
        end
        if (pending) begin
          div_a  <= div_s;
          mode_a <= mode_s;
        end
      end else begin
        if (en) begin
          cnt <= cnt + DIV_W'(1);
        end
        if (mode_a == MODE_TICK) begin
          out_clk <= 1'b0;
        end
      end

      // A write on the applying edge refills the shadow, so pending stays set.
      if (wr) begin
        div_s   <= cfg_div;
        mode_s  <= cfg_mode;
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_div_bank.sv
// clock_div_bank: multi-channel programmable clock-enable generator.
//   sys_clk  - system clock
//   rst      - synchronous active-low reset
//   en       - global count enable
//   cfg_wr   - single-cycle configuration write strobe
//   cfg_ch   - target channel; out-of-range indices are ignored
//   cfg_div  - new divide value (0 is treated as 1)
//   cfg_mode - 0 = tick, 1 = square
//   out_clk  - per-channel registered output
//   pending  - per-channel shadow-config-waiting flag
module clock_div_bank
  import clock_div_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DIV_W       = CLK_DIV_W,
  parameter int unsigned DEFAULT_DIV = CLK_DEFAULT_DIV
) (
  input  logic                                                sys_clk,
  input  logic                                                rst,
  input  logic                                                en,
  input  logic                                                cfg_wr,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]                                    cfg_div,
  input  logic                                                cfg_mode,
  output logic [CHANNELS-1:0]                                 out_clk,
  output logic [CHANNELS-1:0]                                 pending
);

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [DIV_W-1:0]    div_clamped;
  logic [CHANNELS-1:0] wr_ch;

  assign div_clamped = (cfg_div == '0) ? DIV_W'(1) : cfg_div;

  // Exact index match only, so indices >= CHANNELS select nothing.
  always_comb begin
    wr_ch = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wr_ch[i] = cfg_wr && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clock_div_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .en       (en),
      .wr       (wr_ch[g]),
      .cfg_div  (div_clamped),
      .cfg_mode (cfg_mode),
      .out_clk  (out_clk[g]),
      .pending  (pending[g])
    );
  end

endmodule

// File: tb/tb_clock_div_bank.sv
// tb_clock_div_bank: directed + random stimulus against a reference model.
// Three channels are used so that cfg_ch = 3 is an out-of-range index.
module tb_clock_div_bank;

  localparam int CH  = 3;
  localparam int DW  = 8;
  localparam int DEF = 4;

  logic          sys_clk = 1'b0;
  logic          rst;
  logic          en;
  logic          cfg_wr;
  logic [1:0]    cfg_ch;
  logic [DW-1:0] cfg_div;
  logic          cfg_mode;
  logic [CH-1:0] out_clk;
  logic [CH-1:0] pending;

  always #5 sys_clk = ~sys_clk;

  clock_div_bank #(
    .CHANNELS    (CH),
    .DIV_W       (DW),
    .DEFAULT_DIV (DEF)
  ) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .en       (en),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .out_clk  (out_clk),
    .pending  (pending)
  );

  // Reference model: elapsed enabled cycles in the current period, period
  // length, mode, a single shadow slot and the output level.
  int elapsed [CH];
  int period  [CH];
  int nxt_per [CH];
  bit sq      [CH];
  bit nxt_sq  [CH];
  bit has_nxt [CH];
  bit level   [CH];

  int errors = 0;
  int checks = 0;

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      if (!rst) begin
        elapsed[c] = 0; period[c] = DEF; nxt_per[c] = DEF;
        sq[c] = 0; nxt_sq[c] = 0; has_nxt[c] = 0; level[c] = 0;
      end else begin
        bit done;
        bit hit;
        done = en && (elapsed[c] + 1 == period[c]);
        hit  = cfg_wr && (int'(cfg_ch) == c);
        if (done) begin
          if (has_nxt[c] && nxt_sq[c] != sq[c]) level[c] = 0;
          else level[c] = sq[c] ? !level[c] : 1'b1;
          elapsed[c] = 0;
          if (has_nxt[c]) begin
            period[c] = nxt_per[c]; sq[c] = nxt_sq[c]; has_nxt[c] = 0;
          end
        end else begin
          if (en) elapsed[c]++;
          if (!sq[c]) level[c] = 0;
        end
        if (hit) begin
          nxt_per[c] = (cfg_div == 0) ? 1 : int'(cfg_div);
          nxt_sq[c]  = cfg_mode;
          has_nxt[c] = 1;
        end
      end
    end
  endtask

  task automatic check(input string tag);
    logic [CH-1:0] exp_o;
    logic [CH-1:0] exp_p;
    for (int c = 0; c < CH; c++) begin
      exp_o[c] = level[c];
      exp_p[c] = has_nxt[c];
    end
    checks++;
    assert (out_clk === exp_o) else begin
      errors++;
      $error("FAIL %s out_clk observed=%b expected=%b", tag, out_clk, exp_o);
    end
    checks++;
    assert (pending === exp_p) else begin
      errors++;
      $error("FAIL %s pending observed=%b expected=%b", tag, pending, exp_p);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit w, input int ch,
                      input int d, input bit md, input string tag);
    rst = r; en = e; cfg_wr = w; cfg_ch = 2'(ch); cfg_div = DW'(d); cfg_mode = md;
    @(posedge sys_clk);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, tag);
  endtask

  initial begin
    // Reset edge counts as enabled edge 1; ticks follow edges 5, 9, 13.
    step(0, 1, 0, 0, 0, 0, "reset");
    idle(12, "tick_default");
    idle(1, "tick_default");

    // ch1 -> N=3 square while its counter is at 1.
    step(1, 1, 1, 1, 3, 1, "wr_ch1_sq");
    idle(20, "sq_run");

    // ch2: arm a value, then write again exactly on the applying wrap.
    step(1, 1, 1, 2, 5, 0, "wr_ch2_first");
    for (int i = 0; i < 16 && !(elapsed[2] + 1 == period[2]); i++) idle(1, "wait_wrap");
    step(1, 1, 1, 2, 2, 0, "wr_at_wrap");
    checks++;
    assert (pending[2] === 1'b1) else begin
      errors++;
      $error("FAIL wr_at_wrap_pend observed=%b expected=1", pending[2]);
    end
    idle(15, "after_wrap_wr");

    // ch0 -> N=5 square, then freeze mid-period for 7 cycles.
    step(1, 1, 1, 0, 5, 1, "wr_ch0_n5");
    idle(13, "n5_run");
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0, "en_low");
    idle(14, "resume");

    // Zero divide clamps to 1; out-of-range channel write is dropped.
    step(1, 1, 1, 0, 0, 0, "wr_div0");
    idle(12, "div1_tick");
    step(1, 1, 1, 3, 7, 1, "wr_ch_oob");
    idle(4, "after_oob");

    // Reset while a write is pending discards it.
    step(1, 1, 1, 1, 6, 0, "wr_before_rst");
    step(0, 1, 0, 0, 0, 0, "rst_pending");
    idle(10, "post_rst");

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 4) == 0, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 6)), $urandom_range(0, 1) == 1, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
